// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
// Optional WAW kill logic is enabled with the WB_WAW_KILL_EN macro.
package wb_pkg;

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_mul_fifo.sv
// Multiply result queue: circular buffer of wb_entry_t with registered count.
// Under WB_WAW_KILL_EN a kill strobe clears the valid bit of queued entries matching kill_addr.
module wb_mul_fifo
  import wb_pkg::*;
#(
  parameter int unsigned MUL_DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
`ifdef WB_WAW_KILL_EN
  input  logic                         kill,
  input  logic [4:0]                   kill_addr,
`endif
  output wb_entry_t                    head,
  output logic [$clog2(MUL_DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(MUL_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t           mem [MUL_DEPTH];
  logic [PtrW-1:0]     rptr_q, wptr_q;
  logic [CntW-1:0]     count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(MUL_DEPTH); i++) begin
      if (push && (wptr_q == PtrW'(i))) begin
        mem[i] <= push_entry;
      end
`ifdef WB_WAW_KILL_EN
      else if (kill && (mem[i].addr == kill_addr)) begin
        mem[i].valid <= 1'b0;
      end
`endif
    end
  end

  assign head  = mem[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: pipeline writes win the port; multiply results queue and drain when idle.
// WB_WAW_KILL_EN kills queued multiply results overwritten by a pipeline write.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned MUL_DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InValid,
  input  logic        RegWriteIn,
  input  logic        MemtoReg,
  input  logic [4:0]  RAddrIn,
  input  logic [31:0] ALUData,
  input  logic [31:0] MemData,
  input  logic        MulValid,
  input  logic [4:0]  MulRAddr,
  input  logic [31:0] MulData,
  output logic        MulReady,
  output logic        MulPending,
  output logic        RegWriteOut,
  output logic [4:0]  RAddrOut,
  output logic [31:0] RDataOut
);

  localparam int unsigned CntW = $clog2(MUL_DEPTH) + 1;

  logic            pw, push, pop;
  wb_entry_t       push_entry, head;
  logic [CntW-1:0] count;

  logic            regwrite_q, regwrite_d;
  logic [4:0]      raddr_q, raddr_d;
  logic [31:0]     rdata_q, rdata_d;

  wb_mul_fifo #(
    .MUL_DEPTH (MUL_DEPTH)
  ) u_mul_fifo (
    .clock      (Clock),
    .reset      (Reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
`ifdef WB_WAW_KILL_EN
    .kill       (pw),
    .kill_addr  (RAddrIn),
`endif
    .head       (head),
    .count      (count)
  );

  assign pw         = InValid & RegWriteIn & (RAddrIn != ZERO_REG);
  assign MulReady   = (count != CntW'(MUL_DEPTH));
  assign MulPending = (count != '0);
  assign push       = MulValid & MulReady;
  assign pop        = ~pw & MulPending;

  always_comb begin
    push_entry.addr  = MulRAddr;
    push_entry.data  = MulData;
    // r0 pushes are kept so they drain in order, but never write.
    push_entry.valid = (MulRAddr != ZERO_REG);
`ifdef WB_WAW_KILL_EN
    if (pw && (MulRAddr == RAddrIn)) push_entry.valid = 1'b0;
`endif
  end

  always_comb begin
    regwrite_d = 1'b0;
    raddr_d    = raddr_q;
    rdata_d    = rdata_q;
    if (pw) begin
      regwrite_d = 1'b1;
      raddr_d    = RAddrIn;
      rdata_d    = MemtoReg ? MemData : ALUData;
    end else if (pop && head.valid) begin
      regwrite_d = 1'b1;
      raddr_d    = head.addr;
      rdata_d    = head.data;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      regwrite_q <= 1'b0;
      raddr_q    <= '0;
      rdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign RegWriteOut = regwrite_q;
  assign RAddrOut    = raddr_q;
  assign RDataOut    = rdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writes are queued as stimulus is driven and
// checked in order as RegWriteOut fires; handshake flags are checked at each step.
module tb_wb_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid, RegWriteIn, MemtoReg;
  logic [4:0]  RAddrIn;
  logic [31:0] ALUData, MemData;
  logic        MulValid;
  logic [4:0]  MulRAddr;
  logic [31:0] MulData;
  logic        MulReady, MulPending, RegWriteOut;
  logic [4:0]  RAddrOut;
  logic [31:0] RDataOut;

  int ncmp  = 0;
  int nfail = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  wb_stage #(
    .MUL_DEPTH (2)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InValid     (InValid),
    .RegWriteIn  (RegWriteIn),
    .MemtoReg    (MemtoReg),
    .RAddrIn     (RAddrIn),
    .ALUData     (ALUData),
    .MemData     (MemData),
    .MulValid    (MulValid),
    .MulRAddr    (MulRAddr),
    .MulData     (MulData),
    .MulReady    (MulReady),
    .MulPending  (MulPending),
    .RegWriteOut (RegWriteOut),
    .RAddrOut    (RAddrOut),
    .RDataOut    (RDataOut)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Advance one clock; sample 1 time unit after the edge and score any write.
  task automatic cyc();
    wr_t e;
    @(posedge Clock);
    #1;
    if (RegWriteOut === 1'b1) begin
      ncmp++;
      assert (exp_q.size() != 0)
      else begin
        nfail++;
        $error("FAIL unexpected_write: observed r%0d=%h expected no write", RAddrOut, RDataOut);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(RAddrOut), 32'(e.a));
        chk("wr_data", RDataOut, e.d);
      end
    end
  endtask

  task automatic pipe(input logic v, input logic rw, input logic m2r, input logic [4:0] a,
                      input logic [31:0] alu, input logic [31:0] mem);
    InValid    = v;
    RegWriteIn = rw;
    MemtoReg   = m2r;
    RAddrIn    = a;
    ALUData    = alu;
    MemData    = mem;
  endtask

  task automatic mul(input logic v, input logic [4:0] a, input logic [31:0] d);
    MulValid = v;
    MulRAddr = a;
    MulData  = d;
  endtask

  initial begin
    Reset = 1'b1;
    pipe(0, 0, 0, 5'd0, 32'h0, 32'h0);
    mul(0, 5'd0, 32'h0);
    #2;
    chk("rst_we", 32'(RegWriteOut), 32'd0);
    chk("rst_addr", 32'(RAddrOut), 32'd0);
    chk("rst_data", RDataOut, 32'd0);
    chk("rst_ready", 32'(MulReady), 32'd1);
    chk("rst_pending", 32'(MulPending), 32'd0);
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // ALU write, then hold behaviour
    pipe(1, 1, 0, 5'd5, 32'h0000_1234, 32'hFFFF_0000);
    expect_wr(5'd5, 32'h0000_1234);
    cyc();
    chk("alu_we", 32'(RegWriteOut), 32'd1);
    pipe(0, 1, 0, 5'd6, 32'h0000_9999, 32'h0);
    cyc();
    chk("invalid_no_we", 32'(RegWriteOut), 32'd0);
    chk("hold_addr", 32'(RAddrOut), 32'd5);
    chk("hold_data", RDataOut, 32'h0000_1234);

    // Load write; RegWriteIn=0 must not write
    pipe(1, 1, 1, 5'd9, 32'h1111_1111, 32'hDEAD_BEEF);
    expect_wr(5'd9, 32'hDEAD_BEEF);
    cyc();
    chk("load_we", 32'(RegWriteOut), 32'd1);
    pipe(1, 0, 0, 5'd10, 32'h2222_2222, 32'h0);
    cyc();
    chk("rw0_no_we", 32'(RegWriteOut), 32'd0);

    // r0 drop on both paths
    pipe(1, 1, 0, 5'd0, 32'h0000_0077, 32'h0);
    mul(1, 5'd0, 32'h0000_0055);
    cyc();
    chk("r0_no_we", 32'(RegWriteOut), 32'd0);
    chk("r0_pending", 32'(MulPending), 32'd1);
    pipe(0, 0, 0, 5'd0, 32'h0, 32'h0);
    mul(0, 5'd0, 32'h0);
    cyc();
    chk("r0_drain_no_we", 32'(RegWriteOut), 32'd0);
    chk("r0_empty", 32'(MulPending), 32'd0);

    // Back-pressure: pw for 4 cycles, two multiply pushes fill the queue
    pipe(1, 1, 0, 5'd10, 32'h0000_00A0, 32'h0);
    mul(1, 5'd3, 32'h3);
    expect_wr(5'd10, 32'h0000_00A0);
    cyc();
    chk("bp_ready1", 32'(MulReady), 32'd1);
    pipe(1, 1, 0, 5'd10, 32'h0000_00A1, 32'h0);
    mul(1, 5'd4, 32'h4);
    expect_wr(5'd10, 32'h0000_00A1);
    cyc();
    chk("bp_ready_full", 32'(MulReady), 32'd0);
    mul(0, 5'd0, 32'h0);
    for (int k = 2; k < 4; k++) begin
      pipe(1, 1, 0, 5'd10, 32'h0000_00A0 + 32'(k), 32'h0);
      expect_wr(5'd10, 32'h0000_00A0 + 32'(k));
      cyc();
      chk("bp_hold_ready", 32'(MulReady), 32'd0);
      chk("bp_hold_pending", 32'(MulPending), 32'd1);
    end
    pipe(0, 0, 0, 5'd0, 32'h0, 32'h0);
    expect_wr(5'd3, 32'h3);
    expect_wr(5'd4, 32'h4);
    cyc();
    chk("bp_pop1_addr", 32'(RAddrOut), 32'd3);
    chk("bp_pop1_pending", 32'(MulPending), 32'd1);
    chk("bp_pop1_ready", 32'(MulReady), 32'd1);
    cyc();
    chk("bp_pop2_addr", 32'(RAddrOut), 32'd4);
    chk("bp_pop2_pending", 32'(MulPending), 32'd0);

    // Push and pop in the same cycle keep the count
    mul(1, 5'd12, 32'h0000_000C);
    cyc();
    chk("pp_no_fallthrough", 32'(RegWriteOut), 32'd0);
    mul(1, 5'd13, 32'h0000_000D);
    expect_wr(5'd12, 32'h0000_000C);
    expect_wr(5'd13, 32'h0000_000D);
    cyc();
    chk("pp_pending", 32'(MulPending), 32'd1);
    chk("pp_ready", 32'(MulReady), 32'd1);
    mul(0, 5'd0, 32'h0);
    cyc();
    chk("pp_empty", 32'(MulPending), 32'd0);

    // WAW: queued r7 result versus a newer pipeline write to r7
    mul(1, 5'd7, 32'h0000_AAAA);
    cyc();
    mul(0, 5'd0, 32'h0);
    pipe(1, 1, 0, 5'd7, 32'h0000_0011, 32'h0);
    expect_wr(5'd7, 32'h0000_0011);
    cyc();
    chk("waw_pw_data", RDataOut, 32'h0000_0011);
    pipe(0, 0, 0, 5'd0, 32'h0, 32'h0);
`ifdef WB_WAW_KILL_EN
    cyc();
    chk("waw_killed_no_we", 32'(RegWriteOut), 32'd0);
`else
    expect_wr(5'd7, 32'h0000_AAAA);
    cyc();
    chk("waw_stale_we", 32'(RegWriteOut), 32'd1);
`endif
    chk("waw_empty", 32'(MulPending), 32'd0);

    // Reset with two entries queued, asserted between edges
    pipe(1, 1, 0, 5'd1, 32'h0000_0101, 32'h0);
    mul(1, 5'd20, 32'h0000_0020);
    expect_wr(5'd1, 32'h0000_0101);
    cyc();
    pipe(1, 1, 0, 5'd2, 32'h0000_0202, 32'h0);
    mul(1, 5'd21, 32'h0000_0021);
    expect_wr(5'd2, 32'h0000_0202);
    cyc();
    chk("pre_rst_pending", 32'(MulPending), 32'd1);
    chk("pre_rst_ready", 32'(MulReady), 32'd0);
    pipe(0, 0, 0, 5'd0, 32'h0, 32'h0);
    mul(0, 5'd0, 32'h0);
    Reset = 1'b1;
    #1;
    chk("arst_we", 32'(RegWriteOut), 32'd0);
    chk("arst_addr", 32'(RAddrOut), 32'd0);
    chk("arst_data", RDataOut, 32'd0);
    chk("arst_ready", 32'(MulReady), 32'd1);
    chk("arst_pending", 32'(MulPending), 32'd0);
    cyc();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_rst_no_we", 32'(RegWriteOut), 32'd0);
      chk("post_rst_pending", 32'(MulPending), 32'd0);
    end

    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Register write-back stage for the five-stage MIPS core. It merges in-order results from the memory stage with out-of-order results from the multi-cycle multiply unit onto the single register-file write port. It drives the decode stage's `RegWriteIn`, `RAddrIn` and `RData` inputs. Multiply results that lose arbitration wait in a small FIFO, and the multiply unit is back-pressured through a ready/valid handshake.

## Interface
Parameters:
- `MUL_DEPTH`, default 2: multiply result queue depth; a power of two, ≥2.

Ports:
- `Clock`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `InValid`  in  1  memory-stage slot holds a real instruction.
- `RegWriteIn`  in  1  instruction writes a register.
- `MemtoReg`  in  1  1 selects `MemData`, 0 selects `ALUData`.
- `RAddrIn`  in  5  destination register.
- `ALUData`  in  32  ALU result.
- `MemData`  in  32  load data.
- `MulValid`  in  1  multiply result offered.
- `MulRAddr`  in  5  multiply destination register.
- `MulData`  in  32  multiply result.
- `MulReady`  out  1  queue can accept this cycle.
- `MulPending`  out  1  queue non-empty, for the hazard unit.
- `RegWriteOut`  out  1  register-file write enable.
- `RAddrOut`  out  5  write address.
- `RDataOut`  out  32  write data.

## Operation
- Pipeline write: `pw = InValid & RegWriteIn & (RAddrIn != 0)`.
  - Data is `MemtoReg ? MemData : ALUData`.
- Pipeline write has absolute priority for the write port.
- Multiply push: `MulValid & MulReady` enqueues {addr, data, valid=1}.
  - A push with `MulRAddr == 0` enqueues with valid=0, so it is drained silently.
- Pop: in a cycle with no `pw` and a non-empty queue, pop the head.
  - Head valid=1 drives the output registers.
  - Head valid=0 is discarded with no write that cycle.
- Push and pop may occur in the same cycle. The count is unchanged in that case.
- A push into an empty queue cannot pop in the same cycle: there is no fall-through path.
- `MulReady = (count != MUL_DEPTH)`. It is derived from registered count only and has no combinational dependence on a same-cycle pop.
- `MulPending = (count != 0)`.
- Read and write pointers wrap modulo `MUL_DEPTH`. The count is `$clog2(MUL_DEPTH)+1` bits wide.
- No stalls: the memory stage is never back-pressured.

## Timing
- Output registers: `RegWriteOut`, `RAddrOut`, `RDataOut`.
  - Latency is one cycle from a `pw` input cycle or a pop cycle.
  - `RegWriteOut` is 0 in every cycle with no write. `RAddrOut` and `RDataOut` hold their last values.
- Reset, asserted at any time including with entries queued:
  - `RegWriteOut=0`, `RAddrOut=0`, `RDataOut=0`.
  - Queue emptied and pointers zeroed, giving `MulReady=1` and `MulPending=0`.
  - Effect is immediate, not clock-qualified.
- Under sustained `pw`, a full queue holds indefinitely with `MulReady=0`.

## Configuration
- `WB_WAW_KILL_EN` defined: in any cycle with `pw`, every queued entry with addr == `RAddrIn` has its valid bit cleared.
  - A same-cycle push to the same address is also enqueued invalid.
  - This prevents a stale multiply result from overwriting a newer pipeline result.
- Undefined: no kill logic. Write-after-write ordering is the hazard unit's job, using `MulPending`.

## Structure
- `wb_pkg` contains:
  - `typedef struct packed {logic valid; logic [4:0] addr; logic [31:0] data;} wb_entry_t`
  - `localparam ZERO_REG = 5'd0`
- Sub-module `wb_mul_fifo` contains:
  - `wb_entry_t` storage, pointers and count.
  - Push and pop ports.
  - The kill port, an address plus strobe, present only under the macro.
- `wb_stage` contains the priority arbiter and the output registers.

## Test plan
- ALU write: `InValid=1`, `RegWriteIn=1`, `MemtoReg=0`, `RAddrIn=5`, `ALUData=0x00001234` -> next cycle `RegWriteOut=1`, `RAddrOut=5`, `RDataOut=0x00001234`.
- Load write: `MemtoReg=1`, `MemData=0xDEADBEEF`, `RAddrIn=9` -> next cycle write r9 = 0xDEADBEEF.
- r0 drop: pipeline write to r0 and a multiply push to r0 -> `RegWriteOut` never asserted; queue returns to empty.
- Back-pressure: `pw` held for 4 cycles while `MulValid=1` for r3=0x3 and then r4=0x4 (`MUL_DEPTH=2`) -> `MulReady=0` after 2 pushes.
  - After `pw` drops, r3 then r4 are written on consecutive cycles.
  - `MulPending` falls the cycle after the second pop.
- WAW: queue r7=0xAAAA, then `pw` r7=0x11 in the same cycle the queue would otherwise pop.
  - With `WB_WAW_KILL_EN`: only 0x11 is written to r7.
  - Without it: 0x11 is written, then 0xAAAA.
- Reset with 2 entries queued mid-drain -> outputs 0 immediately, `MulReady=1`, `MulPending=0`, no further writes.
